// File: rtl/forward_view_multi.sv
// Pseudo-3D ground-plane renderer: projects each screen pixel onto the world plane along the
// player heading, fetches track colour from the map ROM and overlays opponent karts.
module forward_view_multi #(
    parameter int          HRES        = 1024,
    parameter int          VRES        = 768,
    parameter int          HORIZON     = 384,
    parameter int          NUM_OPP     = 4,
    parameter int          DEPTH_K     = 16384,
    parameter int          FOV_SHIFT   = 9,
    parameter int          MAP_SHIFT   = 3,
    parameter int          MAP_LATENCY = 2,
    parameter int          KART_R      = 8,
    parameter logic [11:0] SKY_COLOR   = 12'h6AF,
    parameter logic [11:0] OOB_COLOR   = 12'h040,
    parameter logic [11:0] OPP_COLOR   = 12'hF00
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [10:0]            hcount_in,
    input  logic [9:0]             vcount_in,
    input  logic [8:0]             direction,
    input  logic [10:0]            player_x,
    input  logic [10:0]            player_y,
    input  logic [11*NUM_OPP-1:0]  opp_x,
    input  logic [11*NUM_OPP-1:0]  opp_y,
    input  logic [NUM_OPP-1:0]     opp_valid,
    output logic [15:0]            map_addr,
    input  logic [11:0]            map_data,
    output logic [11:0]            pixel_out,
    output logic [10:0]            hcount_out,
    output logic [9:0]             vcount_out
);

    localparam logic [10:0]        H_LIMIT   = 11'(HRES);
    localparam logic [9:0]         V_LIMIT   = 10'(VRES);
    localparam logic [9:0]         V_GROUND  = 10'(HORIZON);
    localparam logic signed [31:0] H_MID     = 32'(HRES / 2);
    localparam logic signed [31:0] KART_LIM  = 32'(KART_R);
    localparam logic signed [31:0] WORLD_MAX = 32'sd2047;
    localparam real                PI        = 3.14159265358979323846;

    typedef enum logic [2:0] {
        PIX_BLANK = 3'd0,
        PIX_SKY   = 3'd1,
        PIX_OPP   = 3'd2,
        PIX_OOB   = 3'd3,
        PIX_MAP   = 3'd4
    } pix_class_t;

    typedef struct packed {
        pix_class_t  cls;
        logic [10:0] h;
        logic [9:0]  v;
    } sideband_t;

    function automatic int round_q8(input real x);
        real y;
        y = 256.0 * x;
        return (y >= 0.0) ? $rtoi(y + 0.5) : -$rtoi(0.5 - y);
    endfunction

    // Row depth and heading trig tables are constants; the trig table is 512 deep so headings
    // 360..511 simply alias back onto 0..151.
    logic [15:0]       depth_lut [1024];
    logic signed [9:0] cos_lut   [512];
    logic signed [9:0] sin_lut   [512];

    for (genvar gi = 0; gi < 1024; gi++) begin : g_depth
        localparam int ROW  = gi - HORIZON + 1;
        localparam int DVAL = (ROW > 0) ? DEPTH_K / ((ROW > 0) ? ROW : 1) : 0;
        assign depth_lut[gi] = 16'(DVAL);
    end

    for (genvar gi = 0; gi < 512; gi++) begin : g_trig
        localparam real ANGLE = real'(gi % 360) * PI / 180.0;
        localparam int  COS_V = round_q8($cos(ANGLE));
        localparam int  SIN_V = round_q8($sin(ANGLE));
        assign cos_lut[gi] = 10'(COS_V);
        assign sin_lut[gi] = 10'(SIN_V);
    end

    logic                 frame_start;
    logic [8:0]           dir_sel;
    logic [8:0]           sh_dir;
    logic [10:0]          sh_px, sh_py;
    logic [11*NUM_OPP-1:0] sh_opp_x, sh_opp_y;
    logic [NUM_OPP-1:0]   sh_opp_valid;

    assign frame_start = (hcount_in == 11'd0) && (vcount_in == 10'd0);
    assign dir_sel     = frame_start ? direction : sh_dir;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sh_dir       <= '0;
            sh_px        <= '0;
            sh_py        <= '0;
            sh_opp_x     <= '0;
            sh_opp_y     <= '0;
            sh_opp_valid <= '0;
        end else if (frame_start) begin
            sh_dir       <= direction;
            sh_px        <= player_x;
            sh_py        <= player_y;
            sh_opp_x     <= opp_x;
            sh_opp_y     <= opp_y;
            sh_opp_valid <= opp_valid;
        end
    end

    logic              s1_valid;
    logic [10:0]       s1_h;
    logic [9:0]        s1_v;
    logic [15:0]       s1_d;
    logic signed [9:0] s1_c, s1_s;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_valid <= 1'b0;
            s1_h     <= '0;
            s1_v     <= '0;
            s1_d     <= '0;
            s1_c     <= '0;
            s1_s     <= '0;
        end else begin
            s1_valid <= 1'b1;
            s1_h     <= hcount_in;
            s1_v     <= vcount_in;
            s1_d     <= depth_lut[vcount_in];
            s1_c     <= cos_lut[dir_sel];
            s1_s     <= sin_lut[dir_sel];
        end
    end

    logic signed [31:0] h_off, s1_d_ext, lateral;

    assign h_off    = $signed({21'b0, s1_h}) - H_MID;
    assign s1_d_ext = $signed({16'b0, s1_d});
    assign lateral  = (h_off * s1_d_ext) >>> FOV_SHIFT;

    logic               s2_valid;
    logic [10:0]        s2_h;
    logic [9:0]         s2_v;
    logic [15:0]        s2_d;
    logic signed [9:0]  s2_c, s2_s;
    logic signed [31:0] s2_l;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s2_valid <= 1'b0;
            s2_h     <= '0;
            s2_v     <= '0;
            s2_d     <= '0;
            s2_c     <= '0;
            s2_s     <= '0;
            s2_l     <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_h     <= s1_h;
            s2_v     <= s1_v;
            s2_d     <= s1_d;
            s2_c     <= s1_c;
            s2_s     <= s1_s;
            s2_l     <= lateral;
        end
    end

    logic signed [31:0] d2, c2, sn2, fwd_x, fwd_y, wx_next, wy_next;

    assign d2      = $signed({16'b0, s2_d});
    assign c2      = $signed({{22{s2_c[9]}}, s2_c});
    assign sn2     = $signed({{22{s2_s[9]}}, s2_s});
    assign fwd_x   = (d2 * c2 - s2_l * sn2) >>> 8;
    assign fwd_y   = (d2 * sn2 + s2_l * c2) >>> 8;
    assign wx_next = $signed({21'b0, sh_px}) + fwd_x;
    assign wy_next = $signed({21'b0, sh_py}) + fwd_y;

    logic               s3_valid;
    logic [10:0]        s3_h;
    logic [9:0]         s3_v;
    logic signed [31:0] s3_wx, s3_wy;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s3_valid <= 1'b0;
            s3_h     <= '0;
            s3_v     <= '0;
            s3_wx    <= '0;
            s3_wy    <= '0;
        end else begin
            s3_valid <= s2_valid;
            s3_h     <= s2_h;
            s3_v     <= s2_v;
            s3_wx    <= wx_next;
            s3_wy    <= wy_next;
        end
    end

    logic               world_oob;
    logic [NUM_OPP-1:0] opp_hit;
    sideband_t          sb_next;
    sideband_t          sb_pipe [MAP_LATENCY];

    assign world_oob = (s3_wx < 32'sd0) || (s3_wx > WORLD_MAX) ||
                       (s3_wy < 32'sd0) || (s3_wy > WORLD_MAX);
    assign map_addr  = world_oob ? 16'h0000 : {s3_wy[10:MAP_SHIFT], s3_wx[10:MAP_SHIFT]};

    for (genvar gi = 0; gi < NUM_OPP; gi++) begin : g_opp
        logic signed [31:0] dx, dy;
        assign dx = s3_wx - $signed({21'b0, sh_opp_x[11*gi +: 11]});
        assign dy = s3_wy - $signed({21'b0, sh_opp_y[11*gi +: 11]});
        assign opp_hit[gi] = sh_opp_valid[gi] && (dx <= KART_LIM) && (dx >= -KART_LIM) &&
                             (dy <= KART_LIM) && (dy >= -KART_LIM);
    end

    always_comb begin
        sb_next.h = s3_h;
        sb_next.v = s3_v;
        if (!s3_valid || (s3_h >= H_LIMIT) || (s3_v >= V_LIMIT)) begin
            sb_next.cls = PIX_BLANK;
        end else if (s3_v < V_GROUND) begin
            sb_next.cls = PIX_SKY;
        end else if (|opp_hit) begin
            sb_next.cls = PIX_OPP;
        end else if (world_oob) begin
            sb_next.cls = PIX_OOB;
        end else begin
            sb_next.cls = PIX_MAP;
        end
    end

    // The pixel class rides alongside the ROM read so it lines up with map_data.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int k = 0; k < MAP_LATENCY; k++) begin
                sb_pipe[k] <= '0;
            end
        end else begin
            sb_pipe[0] <= sb_next;
            for (int k = 1; k < MAP_LATENCY; k++) begin
                sb_pipe[k] <= sb_pipe[k-1];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pixel_out  <= '0;
            hcount_out <= '0;
            vcount_out <= '0;
        end else begin
            hcount_out <= sb_pipe[MAP_LATENCY-1].h;
            vcount_out <= sb_pipe[MAP_LATENCY-1].v;
            case (sb_pipe[MAP_LATENCY-1].cls)
                PIX_SKY: pixel_out <= SKY_COLOR;
                PIX_OPP: pixel_out <= OPP_COLOR;
                PIX_OOB: pixel_out <= OOB_COLOR;
                PIX_MAP: pixel_out <= map_data;
                default: pixel_out <= 12'h000;
            endcase
        end
    end

endmodule
